mem_bus_arbiter: RTL and testbench

- Shares one unified single-port memory between the core's instruction-fetch (ROM) port and data (RAM) port.
- Sits between Core and the SoC memory. It serialises each core cycle's fetch and optional data access onto a req/ack memory bus, returns the results, and drives the core's `stall` input until both accesses are complete.
- Data access is always served before the fetch.

---
 rtl/mem_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Serialises a core's data access and instruction fetch onto one req/ack memory bus.
// Optional single-entry fetch buffer enabled by defining MEM_ARB_FETCH_BUFFER_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  output logic              core_stall,
  input  logic [SEL_W-1:0]  rom_write_en,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_write_data,
  output logic [DATA_W-1:0] rom_read_data,
  input  logic              ram_en,
  input  logic [SEL_W-1:0]  ram_write_en,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_write_data,
  output logic [DATA_W-1:0] ram_read_data,
  output logic              mem_req,
  output logic [SEL_W-1:0]  mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] rom_addr_q;
  logic [SEL_W-1:0]  ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;

  // The fetch port is read-only; its write side is intentionally discarded.
  logic unused_rom_write;
  assign unused_rom_write = &{1'b0, rom_write_en, rom_write_data};

  logic              idle_hit;
  logic              dacc_hit;
  logic [DATA_W-1:0] fb_rdata;

`ifdef MEM_ARB_FETCH_BUFFER_EN
  logic              fb_valid;
  logic [ADDR_W-3:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic              store_kill;

  // A store to the buffered word invalidates it before this transaction's fetch lookup.
  assign store_kill = (ram_we_q != '0) && (ram_addr_q[ADDR_W-1:2] == fb_addr);
  assign idle_hit   = fb_valid && (rom_addr[ADDR_W-1:2] == fb_addr);
  assign dacc_hit   = fb_valid && !store_kill && (rom_addr_q[ADDR_W-1:2] == fb_addr);
  assign fb_rdata   = fb_data;
`else
  assign idle_hit   = 1'b0;
  assign dacc_hit   = 1'b0;
  assign fb_rdata   = '0;
`endif

  assign core_stall = stall_in | (state != DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      mem_req       <= 1'b0;
      mem_we        <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      rom_read_data <= '0;
      ram_read_data <= '0;
      rom_addr_q    <= '0;
      ram_we_q      <= '0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
`ifdef MEM_ARB_FETCH_BUFFER_EN
      fb_valid      <= 1'b0;
      fb_addr       <= '0;
      fb_data       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!stall_in) begin
            rom_addr_q  <= rom_addr;
            ram_we_q    <= ram_write_en;
            ram_addr_q  <= ram_addr;
            ram_wdata_q <= ram_write_data;
            if (ram_en) begin
              state <= D_ACC;
            end else if (idle_hit) begin
              rom_read_data <= fb_rdata;
              state         <= DONE;
            end else begin
              state <= I_ACC;
            end
          end
        end

        // Each access state enters with mem_req low and raises it one cycle later,
        // which guarantees an idle bus cycle between consecutive requests.
        D_ACC: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_addr  <= ram_addr_q;
            mem_we    <= ram_we_q;
            mem_wdata <= ram_wdata_q;
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= '0;
            mem_wdata <= '0;
            if (mem_we == '0) begin
              ram_read_data <= mem_rdata;
            end
`ifdef MEM_ARB_FETCH_BUFFER_EN
            if (store_kill) begin
              fb_valid <= 1'b0;
            end
`endif
            if (dacc_hit) begin
              rom_read_data <= fb_rdata;
              state         <= DONE;
            end else begin
              state <= I_ACC;
            end
          end
        end

        I_ACC: begin
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_addr  <= rom_addr_q;
            mem_we    <= '0;
            mem_wdata <= '0;
          end else if (mem_ack) begin
            mem_req       <= 1'b0;
            rom_read_data <= mem_rdata;
`ifdef MEM_ARB_FETCH_BUFFER_EN
            fb_valid      <= 1'b1;
            fb_addr       <= rom_addr_q[ADDR_W-1:2];
            fb_data       <= mem_rdata;
`endif
            state         <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a small latency-programmable memory responder plus
// hand-computed expectations for fetch, load, store, slow memory, stall and reset cases.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        core_stall;
  logic [3:0]  rom_write_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_write_data;
  logic [31:0] rom_read_data;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .core_stall     (core_stall),
    .rom_write_en   (rom_write_en),
    .rom_addr       (rom_addr),
    .rom_write_data (rom_write_data),
    .rom_read_data  (rom_read_data),
    .ram_en         (ram_en),
    .ram_write_en   (ram_write_en),
    .ram_addr       (ram_addr),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after the request has been visible for lat extra cycles.
  int          lat = 0;
  int          cnt = 0;
  int          n_req = 0;
  int          stall_lo = 0;
  bit          prev_req = 1'b0;
  bit          chk_stable = 1'b0;
  logic [31:0] st_addr;
  logic [3:0]  st_we;
  logic [31:0] rq[$];
  logic [31:0] q_addr[$];
  logic [3:0]  q_we[$];
  logic [31:0] q_wd[$];

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!core_stall) stall_lo++;
    if (mem_req) begin
      if (!prev_req) begin
        n_req++;
        q_addr.push_back(mem_addr);
        q_we.push_back(mem_we);
        q_wd.push_back(mem_wdata);
        st_addr = mem_addr;
        st_we   = mem_we;
      end else if (chk_stable) begin
        check_val("stable_addr", mem_addr, st_addr);
        check_val("stable_we", 32'(mem_we), 32'(st_we));
        check_val("stall_held", 32'(core_stall), 32'd1);
      end
      if (cnt == lat) begin
        mem_ack   = 1'b1;
        mem_rdata = (rq.size() > 0) ? rq.pop_front() : 32'h0;
      end
      cnt++;
    end else begin
      cnt = 0;
    end
    prev_req = mem_req;
  end

  // Presents one core cycle's accesses and waits for the DONE cycle (core_stall low).
  task automatic txn(input logic [31:0] ra, input logic re, input logic [3:0] we,
                     input logic [31:0] da, input logic [31:0] wd, output int n);
    rom_addr       = ra;
    ram_en         = re;
    ram_write_en   = we;
    ram_addr       = da;
    ram_write_data = wd;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (core_stall && n < 60);
    if (core_stall) check_val("txn_timeout", 32'(core_stall), 32'd0);
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (!mem_req && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!mem_req) check_val("wait_req_timeout", 32'(mem_req), 32'd1);
  endtask

  int n, b, sl;

  initial begin
    rst            = 1'b0;
    stall_in       = 1'b0;
    rom_write_en   = 4'hF;
    rom_write_data = 32'hFFFF_FFFF;
    rom_addr       = 32'h0;
    ram_en         = 1'b0;
    ram_write_en   = 4'h0;
    ram_addr       = 32'h0;
    ram_write_data = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_mem_wdata", mem_wdata, 32'h0);
    check_val("rst_rom_rd", rom_read_data, 32'h0);
    check_val("rst_ram_rd", ram_read_data, 32'h0);
    check_val("rst_core_stall", 32'(core_stall), 32'd1);
    rst = 1'b1;

    // plain fetch straight out of reset
    rq.push_back(32'h2402_0005);
    b = n_req; sl = stall_lo;
    txn(32'h0, 1'b0, 4'h0, 32'h0, 32'h0, n);
    check_val("f_cycles", n, 3);
    check_val("f_nreq", n_req - b, 1);
    check_val("f_addr", q_addr[b], 32'h0);
    check_val("f_we", 32'(q_we[b]), 32'd0);
    check_val("f_rom_rd", rom_read_data, 32'h2402_0005);
    check_val("f_stall_lo", stall_lo - sl, 1);

    // load then fetch
    rq.push_back(32'hDEAD_BEEF);
    rq.push_back(32'h8C43_0000);
    b = n_req; sl = stall_lo;
    txn(32'h4, 1'b1, 4'h0, 32'h100, 32'h0, n);
    check_val("ld_cycles", n, 6);
    check_val("ld_nreq", n_req - b, 2);
    check_val("ld_addr0", q_addr[b], 32'h100);
    check_val("ld_addr1", q_addr[b+1], 32'h4);
    check_val("ld_we0", 32'(q_we[b]), 32'd0);
    check_val("ld_ram_rd", ram_read_data, 32'hDEAD_BEEF);
    check_val("ld_rom_rd", rom_read_data, 32'h8C43_0000);
    check_val("ld_stall_lo", stall_lo - sl, 1);

    // partial store then fetch
    rq.push_back(32'h1111_1111);
    rq.push_back(32'h3C01_0000);
    b = n_req;
    txn(32'h8, 1'b1, 4'b0011, 32'h200, 32'h0000_ABCD, n);
    check_val("st_cycles", n, 6);
    check_val("st_addr0", q_addr[b], 32'h200);
    check_val("st_we0", 32'(q_we[b]), 32'h3);
    check_val("st_wd0", q_wd[b], 32'h0000_ABCD);
    check_val("st_addr1", q_addr[b+1], 32'h8);
    check_val("st_we1", 32'(q_we[b+1]), 32'd0);
    check_val("st_wd1", q_wd[b+1], 32'h0);
    check_val("st_ram_rd", ram_read_data, 32'hDEAD_BEEF);
    check_val("st_rom_rd", rom_read_data, 32'h3C01_0000);

    // slow memory: five extra wait cycles
    lat = 5; chk_stable = 1'b1;
    rq.push_back(32'hCAFE_F00D);
    sl = stall_lo;
    txn(32'hC, 1'b0, 4'h0, 32'h0, 32'h0, n);
    chk_stable = 1'b0; lat = 0;
    check_val("slow_cycles", n, 9);
    check_val("slow_stall_lo", stall_lo - sl, 1);
    check_val("slow_rom_rd", rom_read_data, 32'hCAFE_F00D);

    // stall_in raised while the fetch is outstanding
    lat = 2;
    rq.push_back(32'h1111_2222);
    rom_addr = 32'h10; ram_en = 1'b0; ram_write_en = 4'h0;
    wait_req();
    stall_in = 1'b1;
    b = n_req; sl = stall_lo;
    repeat (10) begin
      @(negedge clk);
      #1;
    end
    check_val("stl_stall_lo", stall_lo - sl, 0);
    check_val("stl_nreq", n_req - b, 0);
    check_val("stl_rom_rd", rom_read_data, 32'h1111_2222);
    check_val("stl_mem_req", 32'(mem_req), 32'd0);
    check_val("stl_core_stall", 32'(core_stall), 32'd1);
    stall_in = 1'b0; lat = 0;
    b = n_req;
`ifdef MEM_ARB_FETCH_BUFFER_EN
    txn(32'h10, 1'b0, 4'h0, 32'h0, 32'h0, n);
    check_val("rel_cycles", n, 1);
    check_val("rel_nreq", n_req - b, 0);
    check_val("rel_rom_rd", rom_read_data, 32'h1111_2222);
`else
    rq.push_back(32'h3333_4444);
    txn(32'h10, 1'b0, 4'h0, 32'h0, 32'h0, n);
    check_val("rel_cycles", n, 3);
    check_val("rel_nreq", n_req - b, 1);
    check_val("rel_rom_rd", rom_read_data, 32'h3333_4444);
`endif

    // repeated fetch of 0x40, then a store to 0x40 in front of another fetch
    rq.push_back(32'hAAAA_0040);
    txn(32'h40, 1'b0, 4'h0, 32'h0, 32'h0, n);
    check_val("fb1_cycles", n, 4);
    check_val("fb1_rom_rd", rom_read_data, 32'hAAAA_0040);
    b = n_req;
`ifdef MEM_ARB_FETCH_BUFFER_EN
    txn(32'h40, 1'b0, 4'h0, 32'h0, 32'h0, n);
    check_val("fb2_cycles", n, 2);
    check_val("fb2_nreq", n_req - b, 0);
    check_val("fb2_rom_rd", rom_read_data, 32'hAAAA_0040);
`else
    rq.push_back(32'hBBBB_0040);
    txn(32'h40, 1'b0, 4'h0, 32'h0, 32'h0, n);
    check_val("fb2_cycles", n, 4);
    check_val("fb2_nreq", n_req - b, 1);
    check_val("fb2_rom_rd", rom_read_data, 32'hBBBB_0040);
`endif
    rq.push_back(32'h0);
    rq.push_back(32'hCCCC_0040);
    b = n_req;
    txn(32'h40, 1'b1, 4'hF, 32'h40, 32'h1234_5678, n);
    check_val("fb3_cycles", n, 6);
    check_val("fb3_nreq", n_req - b, 2);
    check_val("fb3_addr1", q_addr[b+1], 32'h40);
    check_val("fb3_rom_rd", rom_read_data, 32'hCCCC_0040);

    // reset while a request is outstanding
    lat = 10;
    rom_addr = 32'h50; ram_en = 1'b0; ram_write_en = 4'h0;
    wait_req();
    rst = 1'b0;
    #1;
    check_val("rmid_mem_req", 32'(mem_req), 32'd0);
    check_val("rmid_core_stall", 32'(core_stall), 32'd1);
    check_val("rmid_rom_rd", rom_read_data, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    lat = 0;
    rq.push_back(32'h7777_0050);
    rst = 1'b1;
    b = n_req;
    txn(32'h50, 1'b0, 4'h0, 32'h0, 32'h0, n);
    check_val("rec_cycles", n, 3);
    check_val("rec_nreq", n_req - b, 1);
    check_val("rec_rom_rd", rom_read_data, 32'h7777_0050);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
